// File: rtl/alu_types.sv
// Shared ALU types.
//   alu_control_t      : ALU operation encoding (4 bits; unlisted codes yield result 0)
//   alu_control_name() : short mnemonic for an operation, packed ASCII
//   arb_state_t        : alu_arbiter FSM states
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND = 4'h0,
        ALU_OR  = 4'h1,
        ALU_ADD = 4'h2,
        ALU_XOR = 4'h3,
        ALU_SLL = 4'h4,
        ALU_SRL = 4'h5,
        ALU_SUB = 4'h6,
        ALU_SLT = 4'h7
    } alu_control_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } arb_state_t;

    function automatic logic [23:0] alu_control_name(input alu_control_t c);
        case (c)
            ALU_AND: return "AND";
            ALU_OR:  return "OR ";
            ALU_ADD: return "ADD";
            ALU_XOR: return "XOR";
            ALU_SLL: return "SLL";
            ALU_SRL: return "SRL";
            ALU_SUB: return "SUB";
            ALU_SLT: return "SLT";
            default: return "???";
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   a, b     : operands
//   control  : operation
//   result   : operation result (0 for unlisted control codes)
//   overflow : signed overflow, ADD/SUB only
//   zero     : result == 0
//   equal    : a == b
module alu
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  alu_control_t  control,
    output logic [N-1:0]  result,
    output logic          overflow,
    output logic          zero,
    output logic          equal
);
    localparam int SW = $clog2(N);

    logic [N-1:0] sum;
    logic [N-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (control)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[SW-1:0];
            ALU_SRL: result = a >> b[SW-1:0];
            // Signed overflow: operands agree in sign (ADD) or differ (SUB)
            // and the result sign departs from a.
            ALU_ADD: begin
                result   = sum;
                overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            ALU_SUB: begin
                result   = diff;
                overflow = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            ALU_SLT: result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero  = (result == '0);
    assign equal = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one
// transaction in flight, valid/ready on both request and response sides.
//   clk, rst            : clock, async active-high reset
//   req_valid/req_ready : per-requester request handshake (ready is combinational)
//   req_a/req_b/req_control : per-requester operation payload
//   resp_valid/resp_ready   : per-requester response handshake
//   resp_result, resp_overflow, resp_zero, resp_equal : registered ALU outputs
module alu_arbiter
    import alu_types::*;
#(
    parameter int N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][N-1:0]     req_a,
    input  logic [1:0][N-1:0]     req_b,
    input  alu_control_t [1:0]    req_control,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [N-1:0]          resp_result,
    output logic                  resp_overflow,
    output logic                  resp_zero,
    output logic                  resp_equal
);
    arb_state_t   state;
    logic         grant;
    logic         last_grant;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    alu_control_t op_ctl;
    logic         pick;

    logic [N-1:0] alu_result;
    logic         alu_overflow;
    logic         alu_zero;
    logic         alu_equal;

    // Lone requester wins outright; on contention, the one not served last.
    always_comb begin
        pick = req_valid[1];
        if (req_valid == 2'b11) pick = ~last_grant;
    end

    // Masked by rst so nothing looks accepted while reset is held.
    assign req_ready = (state == S_IDLE && !rst && req_valid[pick])
                     ? (pick ? 2'b10 : 2'b01) : 2'b00;

    alu #(.N(N)) u_alu (
        .a        (op_a),
        .b        (op_b),
        .control  (op_ctl),
        .result   (alu_result),
        .overflow (alu_overflow),
        .zero     (alu_zero),
        .equal    (alu_equal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            op_a          <= '0;
            op_b          <= '0;
            op_ctl        <= ALU_AND;
            resp_valid    <= 2'b00;
            resp_result   <= '0;
            resp_overflow <= 1'b0;
            resp_zero     <= 1'b0;
            resp_equal    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid[pick]) begin
                        op_a   <= req_a[pick];
                        op_b   <= req_b[pick];
                        op_ctl <= req_control[pick];
                        grant  <= pick;
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_result   <= alu_result;
                    resp_overflow <= alu_overflow;
                    resp_zero     <= alu_zero;
                    resp_equal    <= alu_equal;
                    resp_valid    <= grant ? 2'b10 : 2'b01;
                    state         <= S_RESP;
                end
                S_RESP: begin
                    // Only the granted requester's ready retires the response.
                    if (resp_ready[grant]) begin
                        resp_valid <= 2'b00;
                        last_grant <= grant;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_types::*;

    localparam int N          = 32;
    localparam int MAX_ERRORS = 20;
    localparam int SOAK_TXNS  = 200;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_valid = 2'b00;
    logic [1:0]           req_ready;
    logic [1:0][N-1:0]    req_a = '0;
    logic [1:0][N-1:0]    req_b = '0;
    alu_control_t [1:0]   req_control = {ALU_AND, ALU_AND};
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready = 2'b00;
    logic [N-1:0]         resp_result;
    logic                 resp_overflow;
    logic                 resp_zero;
    logic                 resp_equal;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_control   (req_control),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_result   (resp_result),
        .resp_overflow (resp_overflow),
        .resp_zero     (resp_zero),
        .resp_equal    (resp_equal)
    );

    // Reference ALU: {overflow, zero, equal, result}, overflow from a wide signed sum.
    function automatic logic [N+2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [3:0] c);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        logic [N-1:0] r = '0;
        logic o = 1'b0;
        case (c)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h3: r = a ^ b;
            4'h4: r = a << b[4:0];
            4'h5: r = a >> b[4:0];
            4'h2: begin s = sa + sb; r = s[N-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h6: begin s = sa - sb; r = s[N-1:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {o, (r == '0), (a == b), r};
    endfunction

    task automatic do_reset();
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Stimulus only: issue one op on requester r and capture its response.
    task automatic run_txn(input int r, input logic [N-1:0] a, input logic [N-1:0] b,
                           input alu_control_t ctl, output logic [N-1:0] res,
                           output logic ovf, output logic z, output logic eq, output bit ok);
        int c;
        ok = 1'b0; res = '0; ovf = 1'b0; z = 1'b0; eq = 1'b0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        req_a[r] = a; req_b[r] = b; req_control[r] = ctl;
        resp_ready = 2'b00;
        for (c = 0; c < 20; c++) begin @(negedge clk); if (req_ready[r]) break; end
        if (c == 20) begin req_valid = 2'b00; return; end
        @(posedge clk); #1 req_valid = 2'b00;
        for (c = 0; c < 20; c++) begin @(negedge clk); if (resp_valid[r]) break; end
        if (c == 20) return;
        res = resp_result; ovf = resp_overflow; z = resp_zero; eq = resp_equal;
        resp_ready[r] = 1'b1;
        @(posedge clk); #1 resp_ready = 2'b00;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        vectors++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin
            errors++; $display("FAIL reset_handshake: req_ready=%b resp_valid=%b, want 00/00", req_ready, resp_valid);
        end
        vectors++;
        if ({resp_result, resp_overflow, resp_zero, resp_equal} !== '0) begin
            errors++; $display("FAIL reset_outputs: result=%h ovf=%b z=%b eq=%b, want all 0",
                               resp_result, resp_overflow, resp_zero, resp_equal);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        @(posedge clk); #1;
        req_valid = 2'b01; req_a[0] = 32'd5; req_b[0] = 32'd3; req_control[0] = ALU_ADD;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_early: resp_valid=%b want 00", resp_valid); end
        @(negedge clk);
        vectors++;
        if (resp_valid !== 2'b01 || resp_result !== 32'd8 || resp_zero !== 1'b0 ||
            resp_equal !== 1'b0 || resp_overflow !== 1'b0) begin
            errors++; $display("FAIL single_resp: valid=%b result=%0d z=%b eq=%b ovf=%b, want 01/8/0/0/0",
                               resp_valid, resp_result, resp_zero, resp_equal, resp_overflow);
        end
        resp_ready = 2'b01;
        @(posedge clk); #1 resp_ready = 2'b00;
    endtask

    task automatic test_simultaneous();
        logic [1:0] last_mask = 2'b00;
        int k = 0;
        do_reset();
        req_a[0] = 32'd10; req_b[0] = 32'd1; req_control[0] = ALU_ADD;
        req_a[1] = 32'd20; req_b[1] = 32'd2; req_control[1] = ALU_ADD;
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) begin
                vectors++;
                if (resp_valid !== last_mask ||
                    resp_result !== (last_mask[1] ? 32'd22 : 32'd11)) begin
                    errors++; $display("FAIL rr_resp: valid=%b result=%0d, granted mask %b", resp_valid, resp_result, last_mask);
                end
            end
            if (req_ready != 2'b00) begin
                vectors++;
                if (req_ready !== (k[0] ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_grant%0d: req_ready=%b want %b", k, req_ready, (k[0] ? 2'b10 : 2'b01));
                end
                last_mask = req_ready;
                k++;
            end
        end
        vectors++;
        if (k != 4) begin errors++; $display("FAIL rr_timeout: %0d grants seen, want 4", k); end
        req_valid = 2'b00; resp_ready = 2'b00;
    endtask

    task automatic test_backpressure();
        int c;
        do_reset();
        @(posedge clk); #1;
        req_valid = 2'b10; req_a[1] = 32'd9; req_b[1] = 32'd4; req_control[1] = ALU_SUB;
        resp_ready = 2'b01;  // the other requester's ready must be ignored
        for (c = 0; c < 20; c++) begin @(negedge clk); if (req_ready[1]) break; end
        @(posedge clk); #1;
        req_valid = 2'b01; req_a[0] = 32'd1; req_b[0] = 32'd1; req_control[0] = ALU_AND;
        for (c = 0; c < 20; c++) begin @(negedge clk); if (resp_valid != 2'b00) break; end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            vectors++;
            if (resp_valid !== 2'b10 || resp_result !== 32'd5 || resp_overflow !== 1'b0 ||
                resp_zero !== 1'b0 || resp_equal !== 1'b0 || req_ready !== 2'b00) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b result=%0d ovf=%b z=%b eq=%b req_ready=%b, want 10/5/0/0/0/00",
                                   i, resp_valid, resp_result, resp_overflow, resp_zero, resp_equal, req_ready);
            end
        end
        @(posedge clk); #1 resp_ready = 2'b10;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 2'b10) begin errors++; $display("FAIL bp_release: resp_valid=%b want 10", resp_valid); end
        @(posedge clk); #1 resp_ready = 2'b00;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_idle: resp_valid=%b req_ready=%b, want 00/01", resp_valid, req_ready);
        end
        @(posedge clk); #1 req_valid = 2'b00;
    endtask

    task automatic test_overflow_equal();
        logic [N-1:0] res; logic ovf, z, eq; bit ok;
        do_reset();
        run_txn(0, 32'h7fffffff, 32'h1, ALU_ADD, res, ovf, z, eq, ok);
        vectors++;
        if (!ok || res !== 32'h80000000 || ovf !== 1'b1 || z !== 1'b0 || eq !== 1'b0) begin
            errors++; $display("FAIL ovf_add: ok=%b result=%h ovf=%b z=%b eq=%b, want 80000000/1/0/0", ok, res, ovf, z, eq);
        end
        run_txn(1, 32'hdeadbeef, 32'hdeadbeef, ALU_SUB, res, ovf, z, eq, ok);
        vectors++;
        if (!ok || res !== 32'h0 || ovf !== 1'b0 || z !== 1'b1 || eq !== 1'b1) begin
            errors++; $display("FAIL equal_sub: ok=%b result=%h ovf=%b z=%b eq=%b, want 0/0/1/1", ok, res, ovf, z, eq);
        end
        run_txn(0, 32'h80000000, 32'h1, ALU_SUB, res, ovf, z, eq, ok);
        vectors++;
        if (!ok || res !== 32'h7fffffff || ovf !== 1'b1) begin
            errors++; $display("FAIL ovf_sub: ok=%b result=%h ovf=%b, want 7fffffff/1", ok, res, ovf);
        end
        run_txn(1, 32'h12345678, 32'h1, alu_control_t'(4'hf), res, ovf, z, eq, ok);
        vectors++;
        if (!ok || res !== 32'h0 || z !== 1'b1 || ovf !== 1'b0) begin
            errors++; $display("FAIL undef_ctl: ok=%b result=%h z=%b ovf=%b, want 0/1/0", ok, res, z, ovf);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] res; logic ovf, z, eq; bit ok;
        do_reset();
        run_txn(0, 32'd5, 32'd3, ALU_ADD, res, ovf, z, eq, ok);
        @(posedge clk); #1;
        req_valid = 2'b01; req_a[0] = 32'd7; req_b[0] = 32'd7; req_control[0] = ALU_OR;
        @(posedge clk); #2;  // accepted on this edge, now executing
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || resp_result !== 32'd0) begin
            errors++; $display("FAIL rst_mid: req_ready=%b resp_valid=%b result=%h, want 00/00/0", req_ready, resp_valid, resp_result);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 2'b00) begin errors++; $display("FAIL rst_dropped: resp_valid=%b want 00", resp_valid); end
        end
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_first_grant: req_ready=%b want 01", req_ready); end
        @(posedge clk); #1 req_valid = 2'b00;
    endtask

    task automatic test_soak();
        logic [N+2:0] sbq[2][$];
        logic [N+2:0] exp_v;
        bit pend[2] = '{1'b0, 1'b0};
        int issued = 0;
        int done = 0;
        do_reset();
        for (int cyc = 0; cyc < 20000 && done < SOAK_TXNS; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && issued < SOAK_TXNS && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    req_a[i] = $urandom;
                    req_b[i] = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
                    req_control[i] = alu_control_t'(4'(issued % 16));
                    issued++;
                end
                req_valid[i]  = pend[i];
                resp_ready[i] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            vectors++;
            if (req_ready == 2'b11 || resp_valid == 2'b11 || (req_ready != 2'b00 && resp_valid != 2'b00)) begin
                errors++; $display("FAIL soak_onehot: req_ready=%b resp_valid=%b", req_ready, resp_valid);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    sbq[i].push_back(model(req_a[i], req_b[i], req_control[i]));
                    pend[i] = 1'b0;
                end
                if (resp_valid[i] && resp_ready[i]) begin
                    vectors++;
                    done++;
                    if (sbq[i].size() == 0) begin
                        errors++; $display("FAIL soak_spurious: requester %0d response with nothing outstanding", i);
                    end else begin
                        exp_v = sbq[i].pop_front();
                        if ({resp_overflow, resp_zero, resp_equal, resp_result} !== exp_v) begin
                            errors++; $display("FAIL soak_data: req%0d got ovf/z/eq/res=%b%b%b/%h want %b/%h",
                                               i, resp_overflow, resp_zero, resp_equal, resp_result, exp_v[N+2:N], exp_v[N-1:0]);
                        end
                    end
                end
            end
        end
        vectors++;
        if (done != SOAK_TXNS || sbq[0].size() != 0 || sbq[1].size() != 0) begin
            errors++; $display("FAIL soak_count: %0d responses, %0d/%0d outstanding, want %0d/0/0",
                               done, sbq[0].size(), sbq[1].size(), SOAK_TXNS);
        end
        req_valid = 2'b00; resp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        if (errors < MAX_ERRORS) test_single();
        if (errors < MAX_ERRORS) test_simultaneous();
        if (errors < MAX_ERRORS) test_backpressure();
        if (errors < MAX_ERRORS) test_overflow_equal();
        if (errors < MAX_ERRORS) test_reset_mid();
        if (errors < MAX_ERRORS) test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
